// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART receive path.
//   - RX deserialiser state encoding (3-bit constants).
//   - Bit positions inside the 10-bit peripheral read word (dout).
//   - Bit positions of the control bits inside the write word (din).
// ---------------------------------------------------------------------------
package uart_pkg;

    // Receiver state encoding.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    // Read word layout: {err, nonempty, data[7:0]}.
    localparam int ERR_BIT = 9;
    localparam int NE_BIT  = 8;

    // Write word control bits.
    localparam int CLR_BIT   = 0;
    localparam int FLUSH_BIT = 1;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO of 2**DEPTH_LOG2 entries, WIDTH bits each.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   push_i        : write pushData_i (ignored when full unless popping too)
//   pushData_i    : data to store
//   pop_i         : remove head entry (ignored when empty)
//   flush_i       : empty the FIFO; overrides push and pop
//   full_o        : count == depth
//   empty_o       : count == 0
//   head_o        : current head entry (valid when not empty)
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr_q;
    logic [DEPTH_LOG2-1:0] rdPtr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  doPush;
    logic                  doPop;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rdPtr_q];

    // A pop frees a slot in the same cycle, so a push into a full FIFO that
    // is being read at the same time is still accepted.
    assign doPop  = pop_i & ~empty_o;
    assign doPush = push_i & (~full_o | doPop);

    // Pointer and occupancy bookkeeping. Flush discards everything,
    // including a push or pop arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            if (doPush && !doPop) begin
                count_q <= count_q + 1'b1;
            end else if (doPop && !doPush) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage array; contents only matter where the pointers say so,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (doPush && !flush_i) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// 8N1 UART receiver (LSB first) feeding a receive FIFO, exposed on the
// 10-bit peripheral read bus as {err, nonempty, data[7:0]}.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   rxd        : serial input, asynchronous, idle high
//   valid      : peripheral select, held for the whole access
//   wr         : 1 = write, 0 = read (qualified by valid)
//   din        : write data, bit0 clears error flag(s), bit1 flushes FIFO
//   dout       : read data, combinational from FIFO head and flags
// Optional feature macro: UART_RX_FERR_EN
//   defined   -> framing errors set a sticky ferr flag, err = ovf | ferr
//   undefined -> framing errors are silent, err = ovf
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       valid,
    input  logic       wr,
    input  logic [7:0] din,
    output logic [9:0] dout
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(DIV / 2 - 1);

    logic             rxMeta_q;
    logic             rxs_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q;
    logic             ovf_q, ovf_d;
    logic             pushByte;
    logic             frameErr;
    logic             popStrobe;
    logic             wrStrobe;
    logic             flush;
    logic             clearErr;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [7:0]       fifoHead;
    logic             err;
    logic             unusedDin;

    assign unusedDin = ^din[7:2];

    // Bus strobes fire only on the first cycle of an access, so a long
    // valid pulse still pops or acts exactly once.
    assign popStrobe = valid & ~wr & ~valid_q;
    assign wrStrobe  = valid &  wr & ~valid_q;
    assign flush     = wrStrobe & din[FLUSH_BIT];
    assign clearErr  = wrStrobe & din[CLR_BIT];

    // Two-flop synchroniser for the asynchronous line; idles high so reset
    // never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta_q <= 1'b1;
            rxs_q    <= 1'b1;
        end else begin
            rxMeta_q <= rxd;
            rxs_q    <= rxMeta_q;
        end
    end

    // Deserialiser next-state logic. The start bit is rechecked at its
    // midpoint, after which every sample lands mid-bit DIV clocks apart.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        pushByte = 1'b0;
        frameErr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!rxs_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d    = '0;
                    bitIdx_d = '0;
                    state_d  = rxs_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    shift_d  = {rxs_q, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 1'b1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        pushByte = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        frameErr = 1'b1;
                        state_d  = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                // Hold off until the line returns high so a long break
                // cannot be mistaken for a stream of start bits.
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Deserialiser and bus-edge registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            valid_q  <= valid;
        end
    end

    // Overflow is only flagged when the byte is genuinely dropped for lack
    // of space: not when a same-cycle pop makes room, and not when a flush
    // is discarding it anyway. A clear beats a simultaneous set.
    always_comb begin
        ovf_d = ovf_q;
        if (clearErr) begin
            ovf_d = 1'b0;
        end else if (pushByte && fifoFull && !popStrobe && !flush) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

`ifdef UART_RX_FERR_EN
    logic ferr_q;

    // Sticky framing-error flag, cleared by the same control bit as ovf.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr_q <= 1'b0;
        end else if (clearErr) begin
            ferr_q <= 1'b0;
        end else if (frameErr) begin
            ferr_q <= 1'b1;
        end
    end

    assign err = ovf_q | ferr_q;
`else
    logic unusedFrameErr;

    assign unusedFrameErr = frameErr;
    assign err = ovf_q;
`endif

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (8)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (pushByte),
        .pushData_i (shift_q),
        .pop_i      (popStrobe),
        .flush_i    (flush),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .head_o     (fifoHead)
    );

    // Read word: the head byte is masked to zero when the FIFO is empty so
    // stale storage never leaks onto the bus.
    always_comb begin
        dout          = '0;
        dout[ERR_BIT] = err;
        dout[NE_BIT]  = ~fifoEmpty;
        dout[7:0]     = fifoEmpty ? 8'h00 : fifoHead;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo, run at 16 clocks per bit.
// A queue model of the FIFO plus model flags predicts every read word.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;
    localparam int DIV    = CLK_HZ / BAUD;
    localparam int DEPTH  = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rxd   = 1'b1;
    logic       valid = 1'b0;
    logic       wr    = 1'b0;
    logic [7:0] din   = 8'h00;
    logic [9:0] dout;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] modelQ [$];
    logic       ovfM  = 1'b0;
    logic       ferrM = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] expDout;
    } vec_t;

    vec_t vecs [5];

    uart_rx_fifo #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rxd   (rxd),
        .valid (valid),
        .wr    (wr),
        .din   (din),
        .dout  (dout)
    );

    // 10 ns clock period.
    always #5 clk = ~clk;

    // Predicted read word from the model queue and flags.
    function automatic logic [9:0] expectedDout();
        logic e;
        e = ovfM | ferrM;
        if (modelQ.size() == 0) begin
            return {e, 1'b0, 8'h00};
        end
        return {e, 1'b1, modelQ[0]};
    endfunction

    task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one 8N1 frame starting at the current negedge. store=0 means
    // the byte is expected to be lost (reset or flush collision).
    task automatic sendFrame(input logic [7:0] b, input logic stopBit, input bit store);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stopBit;
        repeat (DIV) @(negedge clk);
        if (stopBit && store) begin
            if (modelQ.size() < DEPTH) modelQ.push_back(b);
            else ovfM = 1'b1;
        end
`ifdef UART_RX_FERR_EN
        if (!stopBit) ferrM = 1'b1;
`endif
        repeat (3) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        sendFrame(b, 1'b1, 1'b1);
    endtask

    // Read access holding valid for 'hold' clocks; the word is compared on
    // the first cycle and the model pops once.
    task automatic readAccess(input int hold, input string name, output logic [9:0] seen);
        valid = 1'b1;
        wr    = 1'b0;
        #1;
        seen = dout;
        checkOutput(name, dout, expectedDout());
        if (modelQ.size() != 0) void'(modelQ.pop_front());
        repeat (hold) @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic writeAccess(input logic [7:0] d);
        valid = 1'b1;
        wr    = 1'b1;
        din   = d;
        if (d[FLUSH_BIT]) modelQ.delete();
        if (d[CLR_BIT]) begin
            ovfM  = 1'b0;
            ferrM = 1'b0;
        end
        repeat (2) @(negedge clk);
        valid = 1'b0;
        wr    = 1'b0;
        din   = 8'h00;
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] seen;

        vecs[0] = '{8'hA5, 10'h1A5};
        vecs[1] = '{8'h00, 10'h100};
        vecs[2] = '{8'hFF, 10'h1FF};
        vecs[3] = '{8'h3C, 10'h13C};
        vecs[4] = '{8'h81, 10'h181};

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_dout", dout, 10'h000);
        checkOutput("reset_state", {7'b0, dut.state_q}, {7'b0, ST_IDLE});
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First frame with latency window, then one long read = one pop.
        fork
            sendFrame(8'hA5, 1'b1, 1'b1);
            begin
                repeat (150) @(negedge clk);
                #1 checkOutput("latency_pre", dout, 10'h000);
                repeat (8) @(negedge clk);
                #1 checkOutput("latency_post", dout, 10'h1A5);
            end
        join
        readAccess(3, "read_held3", seen);
        checkOutput("read_held3_const", seen, 10'h1A5);
        readAccess(1, "read_after_one_pop", seen);
        checkOutput("read_after_one_pop_const", seen, 10'h000);

        // Table of single frames, each read straight back.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].data);
            readAccess(1, "vec_sb", seen);
            checkOutput("vec_table", seen, vecs[i].expDout);
        end

        // Back-to-back frames read out in order.
        sendFrame(8'h00, 1'b1, 1'b1);
        sendFrame(8'hFF, 1'b1, 1'b1);
        sendFrame(8'h3C, 1'b1, 1'b1);
        readAccess(1, "b2b_0", seen);
        readAccess(2, "b2b_1", seen);
        readAccess(1, "b2b_2", seen);
        checkOutput("b2b_last_const", seen, 10'h13C);
        #1 checkOutput("b2b_empty", dout, 10'h000);

        // Overflow: 17 bytes into 16 entries.
        for (int b = 1; b <= 17; b++) begin
            sendFrame(8'(b), 1'b1, 1'b1);
        end
        #1 checkOutput("ovf_flag", dout, 10'h301);
        for (int i = 0; i < DEPTH; i++) begin
            readAccess(1, "ovf_drain", seen);
        end
        checkOutput("ovf_last_const", seen, 10'h310);
        #1 checkOutput("ovf_empty", dout, 10'h200);
        writeAccess(8'h01);
        #1 checkOutput("ovf_clear", dout, 10'h000);

        // Short low glitch is rejected at the start-bit midpoint.
        rxd = 1'b0;
        repeat (DIV / 4) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        #1;
        checkOutput("glitch_state", {7'b0, dut.state_q}, {7'b0, ST_IDLE});
        checkOutput("glitch_dout", dout, 10'h000);

        // Framing error: stop bit low, line held low afterwards.
        sendFrame(8'h55, 1'b0, 1'b1);
        repeat (2 * DIV) @(negedge clk);
        #1 checkOutput("break_state", {7'b0, dut.state_q}, {7'b0, ST_BREAK});
        @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("break_exit", {7'b0, dut.state_q}, {7'b0, ST_IDLE});
        checkOutput("ferr_dout", dout, expectedDout());
`ifdef UART_RX_FERR_EN
        checkOutput("ferr_dout_const", dout, 10'h200);
`else
        checkOutput("ferr_dout_const", dout, 10'h000);
`endif
        @(negedge clk);
        writeAccess(8'h01);
        #1 checkOutput("ferr_clear", dout, 10'h000);

        // Flush with content.
        sendFrame(8'h11, 1'b1, 1'b1);
        sendFrame(8'h22, 1'b1, 1'b1);
        sendFrame(8'h33, 1'b1, 1'b1);
        sendFrame(8'h44, 1'b1, 1'b1);
        #1 checkOutput("flush_pre", dout, 10'h111);
        @(negedge clk);
        writeAccess(8'h02);
        #1 checkOutput("flush_post", dout, 10'h000);

        // Flush write lands on the very cycle the stop bit is accepted.
        sendFrame(8'h66, 1'b1, 1'b1);
        fork
            sendFrame(8'h99, 1'b1, 1'b0);
            begin
                repeat (154) @(negedge clk);
                valid = 1'b1;
                wr    = 1'b1;
                din   = 8'h02;
                modelQ.delete();
                @(negedge clk);
                valid = 1'b0;
                wr    = 1'b0;
                din   = 8'h00;
            end
        join
        #1 checkOutput("flush_collision", dout, 10'h000);
        checkOutput("flush_collision_sb", dout, expectedDout());

        // Reset in the middle of a frame discards everything.
        sendFrame(8'h42, 1'b1, 1'b1);
        fork
            sendFrame(8'hC3, 1'b1, 1'b0);
            begin
                repeat (60) @(negedge clk);
                rst_n = 1'b0;
                modelQ.delete();
                ovfM  = 1'b0;
                ferrM = 1'b0;
                #1;
                checkOutput("midrst_dout", dout, 10'h000);
                checkOutput("midrst_state", {7'b0, dut.state_q}, {7'b0, ST_IDLE});
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1 checkOutput("postrst_dout", dout, 10'h000);
        @(negedge clk);
        sendFrame(8'h7E, 1'b1, 1'b1);
        readAccess(1, "postrst_7e", seen);
        checkOutput("postrst_7e_const", seen, 10'h17E);
        readAccess(1, "postrst_empty", seen);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
